// File: rtl/cim_cmd_sequencer_if.sv
// Host command/write/readback channels and CIM processor pins for cim_cmd_sequencer.
// perf_stall is present only when CIM_SEQ_PERF_CNT_EN is defined.
interface cim_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic [2:0]  top_state;
  logic [11:0] top_A;
  logic [31:0] top_D;
  logic        top_out_valid;
  logic [31:0] top_Q;
  logic        busy;
  logic        done;
`ifdef CIM_SEQ_PERF_CNT_EN
  logic [15:0] perf_stall;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
           top_out_valid, top_Q,
    output cmd_ready, wdata_ready, rdata_valid, rdata, top_state, top_A, top_D,
           busy, done, perf_stall
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
           top_out_valid, top_Q,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, top_state, top_A, top_D,
           busy, done, perf_stall
  );
`else
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
           top_out_valid, top_Q,
    output cmd_ready, wdata_ready, rdata_valid, rdata, top_state, top_A, top_D,
           busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
           top_out_valid, top_Q,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, top_state, top_A, top_D,
           busy, done
  );
`endif
endinterface

// File: rtl/cim_cmd_sequencer.sv
// Burst command sequencer driving the CIM processor state/A/D pins, with a small read-return FIFO.
// Optional stall counter output perf_stall enabled by defining CIM_SEQ_PERF_CNT_EN.
module cim_cmd_sequencer #(
  parameter int RFIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cim_cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_GAM       = 3'd1,
    OP_GWM       = 3'd2,
    OP_GIM       = 3'd3,
    OP_STD_WRITE = 3'd4,
    OP_STD_READ  = 3'd5,
    OP_PIP       = 3'd6,
    OP_RGA       = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RUN   = 3'd2,
    S_RD    = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam int PTR_W = $clog2(RFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  if (RFIFO_DEPTH != 2 && RFIFO_DEPTH != 4) begin : g_bad_depth
    $error("cim_cmd_sequencer: RFIFO_DEPTH must be 2 or 4");
  end

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  top_state_q, top_state_d;
  logic [11:0] top_a_q, top_a_d;
  logic [31:0] top_d_q, top_d_d;
  logic        done_q, done_d;

  logic             accept;
  logic             issue_rga;
  logic             bubble;
  logic             push;
  logic             pop;
  logic             ret_dec;
  logic             rd_room;
  logic             drain_empty;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]      mem_q [RFIFO_DEPTH];

  // Returns are only meaningful while a readback burst is active or draining.
  assign push    = bus.top_out_valid && (state_q == S_RD || state_q == S_DRAIN);
  assign pop     = (occ_q != '0) && bus.rdata_ready;
  assign ret_dec = push && (inflight_q != '0);

  // Buffered words plus RGAs still in flight must never exceed the buffer size.
  assign rd_room     = (SUM_W'(occ_q) + SUM_W'(inflight_q)) < SUM_W'(RFIFO_DEPTH);
  assign drain_empty = (inflight_q == CNT_W'(ret_dec));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    top_state_d = OP_NOP;
    top_a_d     = '0;
    top_d_d     = '0;
    done_d      = 1'b0;
    accept      = 1'b0;
    issue_rga   = 1'b0;
    bubble      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          op_d   = op_e'(bus.cmd_op);
          addr_d = bus.cmd_addr;
          cnt_d  = bus.cmd_len;
          case (op_e'(bus.cmd_op))
            OP_NOP:                               done_d  = 1'b1;
            OP_GAM, OP_GWM, OP_GIM, OP_STD_WRITE: state_d = S_WR;
            OP_STD_READ, OP_PIP:                  state_d = S_RUN;
            default:                              state_d = S_RD;
          endcase
        end
      end

      S_WR: begin
        if (bus.wdata_valid) begin
          top_state_d = op_q;
          top_a_d     = addr_q;
          top_d_d     = bus.wdata;
          addr_d      = addr_q + 12'd1;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          bubble = 1'b1;
        end
      end

      S_RUN: begin
        top_state_d = op_q;
        top_a_d     = addr_q;
        addr_d      = addr_q + 12'd1;
        cnt_d       = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_RD: begin
        if (rd_room) begin
          issue_rga   = 1'b1;
          top_state_d = OP_RGA;
          top_a_d     = addr_q;
          addr_d      = addr_q + 12'd1;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_DRAIN;
        end else begin
          bubble = 1'b1;
        end
      end

      S_DRAIN: begin
        if (drain_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    inflight_d = inflight_q + CNT_W'(issue_rga) - CNT_W'(ret_dec);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      cnt_q       <= '0;
      top_state_q <= '0;
      top_a_q     <= '0;
      top_d_q     <= '0;
      done_q      <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      top_state_q <= top_state_d;
      top_a_q     <= top_a_d;
      top_d_q     <= top_d_d;
      done_q      <= done_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: buffer storage has no reset; the read port is gated by occupancy so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.top_Q;
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.wdata_ready = (state_q == S_WR);
  assign bus.rdata_valid = (occ_q != '0);
  assign bus.rdata       = (occ_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
  assign bus.top_state   = top_state_q;
  assign bus.top_A       = top_a_q;
  assign bus.top_D       = top_d_q;
  assign bus.done        = done_q;

`ifdef CIM_SEQ_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (bubble && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.perf_stall = perf_q;
`else
  logic unused_perf;
  assign unused_perf = accept ^ bubble;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ_q == CNT_W'(RFIFO_DEPTH)));

endmodule

// File: tb/tb_cim_cmd_sequencer.sv
// Directed bench for cim_cmd_sequencer: beat/readback scoreboard plus cycle-trace checks.
// A responder returns Q = 0xD00D0000|A one cycle after each RGA appears on the pins.
module tb_cim_cmd_sequencer;
  localparam int DEPTH = 2;
  localparam int TR_N  = 2048;

  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] a;
    logic [31:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cim_cmd_sequencer_if bus ();

  cim_cmd_sequencer #(.RFIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  beat_t       exp_beats [$];
  logic [31:0] exp_words [$];
  logic [31:0] wq [$];
  int          rga_cnt = 0;
  int          pop_cnt = 0;
  int          cyc = 0;

  logic [2:0]  tr_state [TR_N];
  logic [11:0] tr_a     [TR_N];
  logic [31:0] tr_d     [TR_N];
  logic        tr_done  [TR_N];
  logic        tr_ready [TR_N];
  logic        tr_busy  [TR_N];
  logic        tr_ov    [TR_N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] q_of(input logic [11:0] a);
    return 32'hD00D_0000 | {20'h0, a};
  endfunction

  function automatic bit is_write(input logic [2:0] op);
    return (op >= 3'd1 && op <= 3'd4);
  endfunction

  // Per-cycle compare process and trace recorder.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (cyc < TR_N) begin
        tr_state[cyc] = bus.top_state;
        tr_a[cyc]     = bus.top_A;
        tr_d[cyc]     = bus.top_D;
        tr_done[cyc]  = bus.done;
        tr_ready[cyc] = bus.cmd_ready;
        tr_busy[cyc]  = bus.busy;
        tr_ov[cyc]    = bus.top_out_valid;
      end
      cyc++;
      if (rst_n) begin
        if (bus.top_state != 3'd0) begin
          check("beat expected", exp_beats.size() != 0, 1);
          if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            check("beat op", bus.top_state, b.op);
            check("beat A", bus.top_A, b.a);
            check("beat D", bus.top_D, b.d);
          end
          if (bus.top_state == 3'd7) rga_cnt++;
        end else begin
          check("nop A", bus.top_A, 0);
          check("nop D", bus.top_D, 0);
        end
        check("busy vs cmd_ready", bus.busy, !bus.cmd_ready);
        check("buffer bound", (rga_cnt - pop_cnt) <= DEPTH, 1);
        if (bus.rdata_valid && bus.rdata_ready) begin
          check("word expected", exp_words.size() != 0, 1);
          if (exp_words.size() != 0) check("readback word", bus.rdata, exp_words.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  // Processor responder: returns data the cycle after an RGA is on the pins.
  initial begin
    logic        rga_now;
    logic [11:0] a_now;
    bus.top_out_valid = 1'b0;
    bus.top_Q         = 32'h0;
    forever begin
      @(negedge clk);
      rga_now = (bus.top_state == 3'd7);
      a_now   = bus.top_A;
      @(posedge clk);
      #1;
      bus.top_out_valid = rga_now;
      bus.top_Q         = rga_now ? q_of(a_now) : 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] base, input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(base + 32'(i));
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [11:0] a, input logic [7:0] len);
    int   n;
    int   k;
    logic r;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      if (op != 3'd0) exp_beats.push_back('{op, a + 12'(i), is_write(op) ? wq[i] : 32'h0});
      if (op == 3'd7) exp_words.push_back(q_of(a + 12'(i)));
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    k = 0;
    r = 1'b0;
    while (!r && k < 100) begin
      @(negedge clk);
      r = bus.cmd_ready;
      @(posedge clk);
      #1;
      k++;
    end
    check("cmd accepted in budget", r, 1);
    bus.cmd_valid = 1'b0;
  endtask

  // vpat bit k gives wdata_valid for the k-th cycle of the write burst.
  task automatic drive_wdata(input logic [31:0] vpat);
    int   idx;
    int   k;
    logic r;
    idx = 0;
    k   = 0;
    while (idx < wq.size() && k < 200) begin
      bus.wdata_valid = (k < 32) ? vpat[k] : 1'b1;
      bus.wdata       = wq[idx];
      @(negedge clk);
      r = bus.wdata_ready;
      @(posedge clk);
      #1;
      if (r && bus.wdata_valid) idx++;
      k++;
    end
    bus.wdata_valid = 1'b0;
    check("wdata all consumed", idx, wq.size());
  endtask

  task automatic wait_drained(input int budget);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if ((bus.cmd_ready && !bus.rdata_valid) || k >= budget) break;
      k++;
    end
    check("drained in budget", k < budget, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic int first_of(input int from, input logic [2:0] st);
    for (int i = from; i < cyc && i < TR_N - 80; i++) if (tr_state[i] == st) return i;
    return -1;
  endfunction

  function automatic int count_state(input int from, input int to, input logic [2:0] st);
    int n = 0;
    for (int i = from; i < to && i < TR_N; i++) if (tr_state[i] == st) n++;
    return n;
  endfunction

  function automatic int count_done(input int from, input int to);
    int n = 0;
    for (int i = from; i < to && i < TR_N; i++) if (tr_done[i]) n++;
    return n;
  endfunction

  function automatic int count_busy(input int from, input int to);
    int n = 0;
    for (int i = from; i < to && i < TR_N; i++) if (tr_busy[i]) n++;
    return n;
  endfunction

  task automatic find(input string name, input int from, input logic [2:0] st, output int s);
    s = first_of(from, st);
    check(name, s >= 0, 1);
    if (s < 0) s = from;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cmd_ready"},   bus.cmd_ready, 1);
    check({tag, " wdata_ready"}, bus.wdata_ready, 0);
    check({tag, " rdata_valid"}, bus.rdata_valid, 0);
    check({tag, " rdata"},       bus.rdata, 0);
    check({tag, " top_state"},   bus.top_state, 0);
    check({tag, " top_A"},       bus.top_A, 0);
    check({tag, " top_D"},       bus.top_D, 0);
    check({tag, " busy"},        bus.busy, 0);
    check({tag, " done"},        bus.done, 0);
  endtask

  initial begin
    int t0;
    int s;
    int run;
    int pop0;
    int last_ov;
    int done_at;

    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'd0;
    bus.cmd_addr    = 12'h0;
    bus.cmd_len     = 8'd0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = 32'h0;
    bus.rdata_ready = 1'b0;

    idle(3);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // GWM, continuous data.
    set_words(32'hA0, 4);
    send_cmd(3'd2, 12'h000, 8'd3);
    t0 = cyc;
    drive_wdata(32'hFFFF_FFFF);
    idle(3);
    find("gwm beats seen", t0, 3'd2, s);
    for (int i = 0; i < 4; i++) begin
      check("gwm op", tr_state[s+i], 2);
      check("gwm A", tr_a[s+i], i);
      check("gwm D", tr_d[s+i], 32'hA0 + i);
    end
    check("gwm nop after", tr_state[s+4], 0);
    check("gwm done on last beat", tr_done[s+3], 1);
    check("gwm single done", count_done(t0, cyc), 1);
    check("gwm cmd_ready back", tr_ready[s+3], 1);
`ifdef CIM_SEQ_PERF_CNT_EN
    check("gwm perf_stall", bus.perf_stall, 0);
`endif

    // GAM with one stall bubble.
    set_words(32'h10, 3);
    send_cmd(3'd1, 12'h100, 8'd2);
    t0 = cyc;
    drive_wdata(32'hFFFF_FFFD);
    idle(3);
    find("gam beats seen", t0, 3'd1, s);
    check("gam seq0", tr_state[s],   1);
    check("gam seq1", tr_state[s+1], 0);
    check("gam seq2", tr_state[s+2], 1);
    check("gam seq3", tr_state[s+3], 1);
    check("gam A0", tr_a[s],   12'h100);
    check("gam A2", tr_a[s+2], 12'h101);
    check("gam A3", tr_a[s+3], 12'h102);
    check("gam D3", tr_d[s+3], 32'h12);
`ifdef CIM_SEQ_PERF_CNT_EN
    check("gam perf_stall", bus.perf_stall, 1);
`endif

    // PIP, 64 beats.
    send_cmd(3'd6, 12'h040, 8'd63);
    t0 = cyc;
    idle(70);
    find("pip beats seen", t0, 3'd6, s);
    run = 0;
    while (s + run < TR_N && tr_state[s+run] == 3'd6) run++;
    check("pip run length", run, 64);
    check("pip first beat latency", s - t0, 1);
    check("pip last A", tr_a[s+63], 12'h07F);
    check("pip busy while issuing", count_busy(t0, t0 + 64), 64);
    check("pip done at last beat", tr_done[s+63], 1);
    check("pip idle after", tr_busy[s+63], 0);

    // RGA with the host stalled, then released.
    bus.rdata_ready = 1'b0;
    pop0 = pop_cnt;
    send_cmd(3'd7, 12'h020, 8'd4);
    t0 = cyc;
    idle(12);
    check("rga issued while blocked", count_state(t0, cyc, 3'd7), DEPTH);
    @(negedge clk);
    check("rga head valid", bus.rdata_valid, 1);
    check("rga head word", bus.rdata, 32'hD00D_0020);
    check("rga busy while blocked", bus.busy, 1);
    @(posedge clk);
    #1;
    bus.rdata_ready = 1'b1;
    wait_drained(80);
    idle(2);
    check("rga words popped", pop_cnt - pop0, 5);
    check("rga scoreboard empty", exp_words.size(), 0);
    check("rga beats total", count_state(t0, cyc, 3'd7), 5);
    check("rga single done", count_done(t0, cyc), 1);
    last_ov = t0;
    done_at = t0;
    for (int i = t0; i < cyc && i < TR_N; i++) begin
      if (tr_ov[i])   last_ov = i;
      if (tr_done[i]) done_at = i;
    end
    check("rga done after last word", done_at - last_ov, 1);

    // GIM address wrap.
    set_words(32'h11, 2);
    send_cmd(3'd3, 12'hFFF, 8'd1);
    t0 = cyc;
    drive_wdata(32'hFFFF_FFFF);
    idle(3);
    find("gim beats seen", t0, 3'd3, s);
    check("gim A first", tr_a[s], 12'hFFF);
    check("gim A wrapped", tr_a[s+1], 12'h000);
    check("gim op second", tr_state[s+1], 3);

    // NOP command: no beats, done next cycle.
    send_cmd(3'd0, 12'h3C3, 8'd9);
    t0 = cyc;
    idle(3);
    check("nop done", tr_done[t0], 1);
    check("nop no beats", count_state(t0, cyc, 3'd0), cyc - t0);

    // STD_WRITE then back-to-back STD_READ.
    set_words(32'hCAFE_F00D, 1);
    send_cmd(3'd4, 12'h7AB, 8'd0);
    t0 = cyc;
    drive_wdata(32'hFFFF_FFFF);
    send_cmd(3'd5, 12'h010, 8'd2);
    idle(6);
    find("stdw beat seen", t0, 3'd4, s);
    check("stdw A", tr_a[s], 12'h7AB);
    check("stdw D", tr_d[s], 32'hCAFE_F00D);
    check("stdr back-to-back start", first_of(t0, 3'd5) - s, 2);
    check("stdr beats", count_state(t0, cyc, 3'd5), 3);

    // Reset in the middle of a readback burst.
    bus.rdata_ready = 1'b0;
    send_cmd(3'd7, 12'h200, 8'd7);
    idle(6);
    @(negedge clk);
    check("pre-reset head valid", bus.rdata_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_beats.delete();
    exp_words.delete();
    rga_cnt = 0;
    pop_cnt = 0;
    @(negedge clk);
    check_reset_vals("mid-burst reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rdata_ready = 1'b1;
    idle(2);
    set_words(32'h5555_AAAA, 1);
    send_cmd(3'd2, 12'h055, 8'd0);
    t0 = cyc;
    drive_wdata(32'hFFFF_FFFF);
    idle(3);
    find("post-reset beat seen", t0, 3'd2, s);
    check("post-reset A", tr_a[s], 12'h055);
    check("post-reset D", tr_d[s], 32'h5555_AAAA);
    check("post-reset no readback", bus.rdata_valid, 0);
    check("beat scoreboard empty", exp_beats.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
